pixel_lut_stream: RTL and testbench
===================================

# pixel_lut_stream

Multi-channel programmable pixel look-up table for the image pipeline, replacing fixed 256-entry ROM curves. Each colour channel owns a 2^DATA_W-entry table held in block RAM. The tables come up as identity after reset and can be rewritten at run time through a configuration port. Pixels stream through with a valid/ready handshake and a fixed two-cycle latency; back-pressure is supported.

## Interface
- DATA_W, 8, input sample width per channel; table depth = 2^DATA_W
- OUT_W, 8, output sample width per channel
- CHANNELS, 3, number of independent channels/tables
---
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixel this cycle
- in_data  in  CHANNELS*DATA_W  channel c at [c*DATA_W +: DATA_W]
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  CHANNELS*OUT_W  channel c at [c*OUT_W +: OUT_W]
- cfg_we  in  1  table write strobe
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel
- cfg_addr  in  DATA_W  table entry
- cfg_data  in  OUT_W  entry value
- init_done  out  1  identity initialisation finished
- bypass  in  1  present only with PIXEL_LUT_BYPASS_EN

## Operation
- FSM states: INIT, RUN.
- Reset: state=INIT, init counter=0, in_ready=0, out_valid=0, out_data=0, init_done=0.
- INIT: one entry per cycle written to every channel. Written value = addr zero-extended or truncated to OUT_W (MSB-aligned: addr << (OUT_W-DATA_W) when OUT_W>DATA_W, addr >> (DATA_W-OUT_W) otherwise). After 2^DATA_W cycles, state goes to RUN and init_done=1.
- cfg_we is ignored in INIT.
- RUN: cfg_we writes cfg_data to table[cfg_ch][cfg_addr]. cfg_ch >= CHANNELS is ignored.
- Pixel path, two stages:
  - S1: RAM registered read, addressed by in_data per channel.
  - S2: output register.
- stall = out_valid & ~out_ready. While stalled, both stages and the RAM read enable hold and data stays stable.
- in_ready = (state==RUN) & ~stall.
- Accept occurs when in_valid & in_ready.
- out_valid/out_data must not change while out_valid=1 and out_ready=0.
- Reset mid-stream: in-flight pixels are discarded and INIT restarts from entry 0.

## Timing
- Latency: pixel accepted at cycle N appears on out_data at N+2 when there is no stall. Throughput is 1 pixel/cycle.
- INIT lasts exactly 2^DATA_W cycles after rst_n deasserts; in_ready first rises on the cycle init_done rises.
- Write/read same cycle, same entry: the lookup returns the old value. Lookups accepted from the next cycle return the new value.
- A cfg write never stalls the pixel path. The RAM is 1R1W simple dual-port.

## Configuration
- PIXEL_LUT_BYPASS_EN defined:
  - The bypass port exists.
  - A pixel accepted with bypass=1 outputs in_data width-converted exactly as the INIT rule, with the same two-cycle latency and ordering.
  - bypass is sampled per pixel at accept.
- Undefined: no bypass port; all pixels go through the tables.

## Structure
- pixel_lut_pkg holds:
  - state enum {INIT, RUN};
  - the width-conversion function, used for identity init and bypass;
  - the localparam DEPTH = 1<<DATA_W helper.
- Sub-module lut_ram: 1R1W, registered read with read enable, (* rom_style="block" *)-style RAM attribute. Instantiated CHANNELS times via generate.

## Test plan
- Reset release, DATA_W=8/OUT_W=8/CHANNELS=3 -> init_done after exactly 256 cycles; pixel {10,20,30} -> out {10,20,30} two cycles after accept.
- Program ch1 addr 20 = 200, then stream {10,20,30} -> out {10,200,30}; write and lookup in same cycle -> old value 20, next pixel -> 200.
- out_ready held low 5 cycles with 4 pixels offered -> in_ready drops; no loss, duplication or reorder; out_data stable while stalled.
- rst_n asserted mid-stream with 2 pixels in flight -> out_valid=0 immediately; INIT reruns; no stale pixel emerges.
- DATA_W=8, OUT_W=10: identity of 255 -> 1020. With PIXEL_LUT_BYPASS_EN, bypass=1 on pixel 5 of a stream -> that pixel passes through converted, neighbours are looked up.

Source files
------------

// File: rtl/pixel_lut_pkg.sv
// Shared types and helpers for the programmable pixel look-up table.
// Optional feature macro: PIXEL_LUT_BYPASS_EN (adds a per-pixel bypass input).
package pixel_lut_pkg;

    // Controller states: identity fill after reset, then normal streaming.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Nominal sample width and the matching table depth.
    localparam int LUT_DATA_W = 8;
    localparam int DEPTH      = 1 << LUT_DATA_W;

    // Working width of the conversion helper; wide enough for any sane sample width.
    localparam int CONV_W = 32;

    // Table depth for an arbitrary input sample width.
    function automatic int lut_depth(input int data_w);
        return 1 << data_w;
    endfunction

    // MSB-aligned width conversion: widen by shifting left, narrow by dropping LSBs.
    // Used both for the identity fill and for bypassed pixels so the two agree exactly.
    function automatic logic [CONV_W-1:0] width_convert(
        input logic [CONV_W-1:0] value,
        input int                in_w,
        input int                out_w
    );
        if (out_w >= in_w) begin
            return value << (out_w - in_w);
        end else begin
            return value >> (in_w - out_w);
        end
    endfunction

endpackage

// File: rtl/lut_ram.sv
// Simple dual-port table RAM: one write port, one registered read port with enable.
// Read-during-write to the same entry returns the previous contents.
module lut_ram
    import pixel_lut_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read; holding re low freezes the output word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pixel_lut_stream.sv
// Multi-channel programmable pixel LUT with a two-stage valid/ready pipeline.
// Each channel owns a 2^DATA_W-entry table, filled with an identity curve after
// reset and rewritable at run time through the cfg_* port.
// Optional feature macro: PIXEL_LUT_BYPASS_EN adds the bypass input; a pixel accepted
// with bypass=1 leaves as its own input, width-converted like the identity curve.
module pixel_lut_stream
    import pixel_lut_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 8,
    parameter int CHANNELS = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0]                 in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [CHANNELS*OUT_W-1:0]                  out_data,
    input  logic                                       cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [DATA_W-1:0]                          cfg_addr,
    input  logic [OUT_W-1:0]                           cfg_data,
`ifdef PIXEL_LUT_BYPASS_EN
    input  logic                                       bypass,
`endif
    output logic                                       init_done
);

    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LUT_DEPTH = lut_depth(DATA_W);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [DATA_W-1:0] init_cnt_q;
    logic              init_done_q;

    // Pipeline state
    logic                      s1_valid_q, s1_valid_d;
    logic                      out_valid_q, out_valid_d;
    logic [CHANNELS*OUT_W-1:0] out_data_q, out_data_d;

    // Handshake
    logic stall;
    logic advance;
    logic accept;
    logic init_phase;

    // Table write port, shared by the identity fill and the cfg port
    logic [CHANNELS-1:0]       ram_we;
    logic [DATA_W-1:0]         ram_waddr;
    logic [OUT_W-1:0]          ram_wdata;
    logic [OUT_W-1:0]          init_value;
    logic [CHANNELS*OUT_W-1:0] ram_rdata;

    // A held output blocks both stages; the RAM read enable follows the same rule
    // so the looked-up word of the pixel in stage 1 is not overwritten.
    assign stall      = out_valid_q & ~out_ready;
    assign advance    = ~stall;
    assign in_ready   = (state_q == RUN) & ~stall;
    assign accept     = in_valid & in_ready;
    assign init_phase = (state_q == INIT);

    // Identity value for the entry currently being filled.
    assign init_value = OUT_W'(width_convert(CONV_W'(init_cnt_q), DATA_W, OUT_W));

    // The fill owns the write port during INIT; cfg writes are only honoured in RUN.
    assign ram_waddr = init_phase ? init_cnt_q : cfg_addr;
    assign ram_wdata = init_phase ? init_value : cfg_data;

    // Controller: walk every table entry once, then stay in RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + DATA_W'(1);
                    if (32'(init_cnt_q) == LUT_DEPTH - 1) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign init_done = init_done_q;

    // ------------------------------------------------------------------
    // Per-channel tables
    // ------------------------------------------------------------------
`ifdef PIXEL_LUT_BYPASS_EN
    logic [CHANNELS*OUT_W-1:0] in_conv;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Out-of-range channel numbers never match any table, so they are dropped.
        assign ram_we[gi] = init_phase | (cfg_we & (cfg_ch == CH_W'(gi)));

        lut_ram #(
            .ADDR_W (DATA_W),
            .DATA_W (OUT_W)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[gi]),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .re    (advance),
            .raddr (in_data[gi*DATA_W +: DATA_W]),
            .rdata (ram_rdata[gi*OUT_W +: OUT_W])
        );

`ifdef PIXEL_LUT_BYPASS_EN
        assign in_conv[gi*OUT_W +: OUT_W] =
            OUT_W'(width_convert(CONV_W'(in_data[gi*DATA_W +: DATA_W]), DATA_W, OUT_W));
`endif
    end

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
`ifdef PIXEL_LUT_BYPASS_EN
    logic                      s1_byp_q, s1_byp_d;
    logic [CHANNELS*OUT_W-1:0] s1_conv_q, s1_conv_d;

    // Bypass flag and converted pixel travel alongside the RAM read in stage 1.
    always_comb begin
        s1_byp_d  = s1_byp_q;
        s1_conv_d = s1_conv_q;
        if (advance) begin
            s1_byp_d  = accept & bypass;
            s1_conv_d = in_conv;
        end
    end

    // Stage-1 bypass side-band registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_byp_q  <= 1'b0;
            s1_conv_q <= '0;
        end else begin
            s1_byp_q  <= s1_byp_d;
            s1_conv_q <= s1_conv_d;
        end
    end
`endif

    // Next-state for both stages: everything freezes while the output is stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (advance) begin
            s1_valid_d  = accept;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
`ifdef PIXEL_LUT_BYPASS_EN
                out_data_d = s1_byp_q ? s1_conv_q : ram_rdata;
`else
                out_data_d = ram_rdata;
`endif
            end
        end
    end

    // Pipeline valid bits and output register; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pixel_lut_stream.sv
// Directed testbench for pixel_lut_stream (3 channels, 8-bit in/out) plus a
// single-channel 8-to-10-bit instance for the widening identity curve.
`timescale 1ns/1ps
module tb_pixel_lut_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        init_done;
`ifdef PIXEL_LUT_BYPASS_EN
    logic        bypass;
`endif

    // Single-channel widening instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic        b_out_valid;
    logic [9:0]  b_out_data;
    logic        b_cfg_we;
    logic [0:0]  b_cfg_ch;
    logic [7:0]  b_cfg_addr;
    logic [9:0]  b_cfg_data;
    logic        b_init_done;
`ifdef PIXEL_LUT_BYPASS_EN
    logic        b_bypass;
`endif

    int checks   = 0;
    int failures = 0;

    // Stream helper state
    logic [23:0] pix_q [$];
    logic        byp_q [$];
    logic [23:0] got_q [$];
    int          unstable;
    logic        saw_ready_low;

    pixel_lut_stream #(.DATA_W(8), .OUT_W(8), .CHANNELS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
`ifdef PIXEL_LUT_BYPASS_EN
        .bypass    (bypass),
`endif
        .init_done (init_done)
    );

    pixel_lut_stream #(.DATA_W(8), .OUT_W(10), .CHANNELS(1)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (1'b1),
        .out_data  (b_out_data),
        .cfg_we    (b_cfg_we),
        .cfg_ch    (b_cfg_ch),
        .cfg_addr  (b_cfg_addr),
        .cfg_data  (b_cfg_data),
`ifdef PIXEL_LUT_BYPASS_EN
        .bypass    (b_bypass),
`endif
        .init_done (b_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pix3(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive pix_q through the DUT, holding out_ready low for low_len cycles starting at
    // cycle low_from; collects delivered pixels into got_q and notes output instability.
    task automatic stream(input int low_from, input int low_len, input int budget, output int cycles);
        int          sent;
        int          cyc;
        logic        held_v;
        logic [23:0] held;
        sent = 0;
        cyc = 0;
        held_v = 1'b0;
        held = '0;
        got_q.delete();
        unstable = 0;
        saw_ready_low = 1'b0;
        while (got_q.size() < pix_q.size() && cyc < budget) begin
            out_ready = !(cyc >= low_from && cyc < low_from + low_len);
            in_valid  = (sent < pix_q.size());
            in_data   = in_valid ? pix_q[sent] : 24'h0;
`ifdef PIXEL_LUT_BYPASS_EN
            bypass    = in_valid ? byp_q[sent] : 1'b0;
`endif
            #1;
            if (held_v && (!out_valid || out_data !== held)) unstable++;
            if (in_valid && !in_ready) saw_ready_low = 1'b1;
            if (out_valid && out_ready) got_q.push_back(out_data);
            held_v = out_valid && !out_ready;
            held   = out_data;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef PIXEL_LUT_BYPASS_EN
        bypass    = 1'b0;
`endif
        cycles = cyc;
    endtask

    task automatic test_reset();
        int   n;
        logic early_ready;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 000000", out_data); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        rst_n = 1'b1;
        n = 0;
        early_ready = 1'b0;
        // Late in INIT, try to overwrite ch2 entry 40; this must be ignored.
        cfg_ch = 2'd2; cfg_addr = 8'd40; cfg_data = 8'd7;
        while (!init_done && n < 1000) begin
            cfg_we = (n >= 100);
            if (in_ready) early_ready = 1'b1;
            tick();
            n++;
        end
        cfg_we = 1'b0;
        checks++; if (n !== 256) begin failures++; $display("FAIL init_cycles: got %0d expected 256", n); end
        checks++; if (early_ready !== 1'b0) begin failures++; $display("FAIL ready_during_init: got %b expected 0", early_ready); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_init: got %b expected 1", in_ready); end
        checks++; if (b_init_done !== 1'b1) begin failures++; $display("FAIL init_done_w10: got %b expected 1", b_init_done); end
        $display("test_reset: init took %0d cycles", n);
    endtask

    task automatic test_identity();
        in_valid = 1'b1; in_data = pix3(8'd10, 8'd20, 8'd30);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL identity_early: out_valid got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL identity_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== pix3(8'd10, 8'd20, 8'd30)) begin failures++; $display("FAIL identity_data: got %h expected %h", out_data, pix3(8'd10, 8'd20, 8'd30)); end
        $display("test_identity: in {10,20,30} out %h", out_data);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL identity_single: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_width10();
        b_in_valid = 1'b1; b_in_data = 8'd255;
        tick();
        b_in_data = 8'd3;
        tick();
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 10'd1020) begin failures++; $display("FAIL w10_255: got valid=%b data=%0d expected 1/1020", b_out_valid, b_out_data); end
        $display("test_width10: 255 -> %0d", b_out_data);
        tick();
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 10'd12) begin failures++; $display("FAIL w10_3: got valid=%b data=%0d expected 1/12", b_out_valid, b_out_data); end
        $display("test_width10: 3 -> %0d", b_out_data);
        tick();
    endtask

    task automatic test_cfg_write();
        int cyc;
        // Same-cycle write and lookup of ch0 entry 50: first pixel sees old, next sees new.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 8'd50; cfg_data = 8'd99;
        in_valid = 1'b1; in_data = pix3(8'd50, 8'd50, 8'd50);
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== pix3(8'd50, 8'd50, 8'd50)) begin failures++; $display("FAIL same_cycle_old: got %b/%h expected 1/%h", out_valid, out_data, pix3(8'd50, 8'd50, 8'd50)); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== pix3(8'd99, 8'd50, 8'd50)) begin failures++; $display("FAIL next_cycle_new: got %b/%h expected 1/%h", out_valid, out_data, pix3(8'd99, 8'd50, 8'd50)); end
        $display("test_cfg_write: same-cycle lookup done, new value %h", out_data);
        tick();
        // Program ch1 entry 20 = 200, and attempt a write to nonexistent channel 3.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_addr = 8'd20; cfg_data = 8'd200;
        tick();
        cfg_ch = 2'd3; cfg_addr = 8'd30; cfg_data = 8'd1;
        tick();
        cfg_we = 1'b0;
        pix_q = '{pix3(8'd10, 8'd20, 8'd30), pix3(8'd30, 8'd30, 8'd40)};
        byp_q = '{1'b0, 1'b0};
        stream(100, 0, 50, cyc);
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL cfg_count: got %0d expected 2", got_q.size()); end
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== pix3(8'd10, 8'd200, 8'd30)) begin failures++; $display("FAIL cfg_ch1: got %h expected %h", got_q[0], pix3(8'd10, 8'd200, 8'd30)); end
            checks++; if (got_q[1] !== pix3(8'd30, 8'd30, 8'd40)) begin failures++; $display("FAIL cfg_ignored: got %h expected %h", got_q[1], pix3(8'd30, 8'd30, 8'd40)); end
            $display("test_cfg_write: out %h %h", got_q[0], got_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [23:0] exp_q [$];
        pix_q = '{pix3(8'd1, 8'd2, 8'd3), pix3(8'd4, 8'd5, 8'd6), pix3(8'd255, 8'd0, 8'd128),
                  pix3(8'd7, 8'd8, 8'd9), pix3(8'd60, 8'd20, 8'd61), pix3(8'd0, 8'd255, 8'd0)};
        byp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_q = '{pix3(8'd1, 8'd2, 8'd3), pix3(8'd4, 8'd5, 8'd6), pix3(8'd255, 8'd0, 8'd128),
                  pix3(8'd7, 8'd8, 8'd9), pix3(8'd60, 8'd200, 8'd61), pix3(8'd0, 8'd255, 8'd0)};
        stream(100, 0, 50, cyc);
        checks++; if (cyc !== 8) begin failures++; $display("FAIL b2b_cycles: got %0d expected 8", cyc); end
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL b2b_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_px%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            $display("test_back_to_back: px%0d out %h", i, got_q[i]);
        end
    endtask

    task automatic test_stall();
        int          cyc;
        logic [23:0] exp_q [$];
        pix_q = '{pix3(8'd11, 8'd12, 8'd13), pix3(8'd21, 8'd22, 8'd23), pix3(8'd31, 8'd32, 8'd33), pix3(8'd41, 8'd42, 8'd43)};
        byp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_q = pix_q;
        stream(2, 5, 60, cyc);
        checks++; if (saw_ready_low !== 1'b1) begin failures++; $display("FAIL stall_ready_drop: got %b expected 1", saw_ready_low); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable); end
        checks++; if (cyc !== 11) begin failures++; $display("FAIL stall_cycles: got %0d expected 11", cyc); end
        checks++; if (got_q.size() !== 4) begin failures++; $display("FAIL stall_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_px%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            $display("test_stall: px%0d out %h", i, got_q[i]);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_dup: out_valid got %b expected 0", out_valid); end
    endtask

`ifdef PIXEL_LUT_BYPASS_EN
    task automatic test_bypass();
        int cyc;
        pix_q = '{pix3(8'd10, 8'd20, 8'd30), pix3(8'd10, 8'd20, 8'd30), pix3(8'd10, 8'd20, 8'd30),
                  pix3(8'd10, 8'd20, 8'd30), pix3(8'd10, 8'd20, 8'd30), pix3(8'd10, 8'd20, 8'd30)};
        byp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        stream(100, 0, 50, cyc);
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL byp_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            checks++;
            if (got_q[i] !== ((i == 4) ? pix3(8'd10, 8'd20, 8'd30) : pix3(8'd10, 8'd200, 8'd30))) begin
                failures++; $display("FAIL byp_px%0d: got %h", i, got_q[i]);
            end
            $display("test_bypass: px%0d out %h", i, got_q[i]);
        end
    endtask
`endif

    task automatic test_reset_midstream();
        int n;
        int stray;
        int cyc;
        in_valid = 1'b1; in_data = pix3(8'd10, 8'd20, 8'd30);
        tick();
        in_data = pix3(8'd50, 8'd20, 8'd30);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0 || init_done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got ready=%b done=%b expected 0/0", in_ready, init_done); end
        tick();
        rst_n = 1'b1;
        n = 0;
        stray = 0;
        while (!init_done && n < 1000) begin
            if (out_valid) stray++;
            tick();
            n++;
        end
        checks++; if (n !== 256) begin failures++; $display("FAIL midrst_init_cycles: got %0d expected 256", n); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL midrst_stale: got %0d outputs expected 0", stray); end
        // Entries modified earlier must be back to identity.
        pix_q = '{pix3(8'd50, 8'd20, 8'd40)};
        byp_q = '{1'b0};
        stream(100, 0, 50, cyc);
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL midrst_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() == 1) begin
            checks++; if (got_q[0] !== pix3(8'd50, 8'd20, 8'd40)) begin failures++; $display("FAIL midrst_identity: got %h expected %h", got_q[0], pix3(8'd50, 8'd20, 8'd40)); end
            $display("test_reset_midstream: out %h after %0d init cycles", got_q[0], n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
        b_in_valid = 1'b0; b_in_data = '0;
        b_cfg_we = 1'b0; b_cfg_ch = '0; b_cfg_addr = '0; b_cfg_data = '0;
`ifdef PIXEL_LUT_BYPASS_EN
        bypass = 1'b0; b_bypass = 1'b0;
`endif
        test_reset();
        test_identity();
        test_width10();
        test_cfg_write();
        test_back_to_back();
        test_stall();
`ifdef PIXEL_LUT_BYPASS_EN
        test_bypass();
`endif
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
